// File: rtl/sram_b_stream_reader_if.sv
// Bundles the command, SRAM and output-stream signals of the operand-B stream reader.
// The reader takes the slave modport; the sequencer/SRAM/consumer side takes master.
interface sram_b_stream_reader_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 11
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base;
  logic [LEN_W-1:0]  cmd_len;

  logic              mem_ce;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              done;

  modport slave (
    input  cmd_valid, cmd_base, cmd_len, mem_dout, out_ready,
    output cmd_ready, mem_ce, mem_we, mem_addr, mem_din, out_valid, out_data, out_last, done
  );

  modport master (
    output cmd_valid, cmd_base, cmd_len, mem_dout, out_ready,
    input  cmd_ready, mem_ce, mem_we, mem_addr, mem_din, out_valid, out_data, out_last, done
  );
endinterface

// File: rtl/sram_b_stream_reader.sv
// Operand-B scratchpad reader: sequential wrapped reads from a 1-cycle SRAM, streamed out
// through a small skid FIFO so the read latency is hidden and backpressure is lossless.
module sram_b_stream_reader #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned LEN_W      = 11,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic                  clk,
  input logic                  rst,
  sram_b_stream_reader_if.slave bus
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, addr_q;
  logic [LEN_W-1:0]  len_q, issued_q, beats_q;
  logic              inflight_q;

  logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [CntW-1:0]   count_q;

  logic              pop, push, issue, out_valid, out_last, cmd_ready, done;
  logic [CntW:0]     occ;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] out_data;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    out_valid = (count_q != '0);
    out_data  = out_valid ? fifo_q[rptr_q] : '0;
    out_last  = out_valid && (beats_q == len_q - LEN_W'(1));
    pop       = out_valid & bus.out_ready;
    push      = inflight_q;
    // Entries already committed to the FIFO once the in-flight read lands, net of this pop.
    occ       = (CntW+1)'(count_q) + (CntW+1)'(inflight_q) - (CntW+1)'(pop);
    issue     = (state_q == StRun) && (issued_q < len_q) && (occ < (CntW+1)'(FIFO_DEPTH));
    mem_addr  = issue ? base_q + issued_q[ADDR_W-1:0] : addr_q;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) state_d = (bus.cmd_len == '0) ? StDone : StRun;
      end
      StRun:   if (pop && out_last) state_d = StDone;
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      base_q     <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      beats_q    <= '0;
      inflight_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (issue) begin
        issued_q <= issued_q + LEN_W'(1);
        addr_q   <= mem_addr;
      end
      if (pop) beats_q <= beats_q + LEN_W'(1);
      if (state_q == StIdle && bus.cmd_valid) begin
        base_q   <= bus.cmd_base;
        len_q    <= bus.cmd_len;
        issued_q <= '0;
        beats_q  <= '0;
      end
      if (push) begin
        fifo_q[wptr_q] <= bus.mem_dout;
        wptr_q         <= ptr_inc(wptr_q);
      end
      if (pop) rptr_q <= ptr_inc(rptr_q);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (!push && pop) count_q <= count_q - CntW'(1);
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.mem_ce    = issue;
  assign bus.mem_we    = 1'b0;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_din   = '0;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_last  = out_last;
  assign bus.done      = done;

`ifndef SYNTHESIS
  fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count_q == CntW'(FIFO_DEPTH)));
`endif

endmodule

// File: tb/tb_sram_b_stream_reader.sv
// Directed bench for sram_b_stream_reader with a 1-cycle SRAM model (m[i] = i[7:0]).
module tb_sram_b_stream_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_b_stream_reader_if #(.ADDR_W(10), .DATA_W(8), .LEN_W(11)) bus ();

  sram_b_stream_reader #(.ADDR_W(10), .DATA_W(8), .LEN_W(11), .FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [7:0] sram [1024];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) if (bus.mem_ce) bus.mem_dout <= sram[bus.mem_addr];

  // Consumer ready: held high, or a coin flip per cycle when rnd_mode is set.
  logic rnd_mode = 1'b0;
  always begin
    @(posedge clk);
    #1;
    bus.out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: log handshaken beats and issued addresses; check stall stability.
  logic [7:0] beat_data [$];
  logic       beat_last [$];
  int         beat_cyc  [$];
  int         addr_log  [$];
  int         cyc = 0;
  int         vcount = 0;
  logic       stall_prev = 1'b0;
  logic [9:0] prev_beat;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check_eq("stall_hold", {22'b0, bus.out_valid, bus.out_last, bus.out_data},
                 {22'b0, prev_beat});
      if (bus.out_valid && bus.out_ready) begin
        beat_data.push_back(bus.out_data);
        beat_last.push_back(bus.out_last);
        beat_cyc.push_back(cyc);
      end
      if (bus.mem_ce) addr_log.push_back(int'(bus.mem_addr));
      if (bus.out_valid) vcount++;
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_beat  = {1'b1, bus.out_last, bus.out_data};
    end
  end

  task automatic clear_logs();
    beat_data.delete();
    beat_last.delete();
    beat_cyc.delete();
    addr_log.delete();
    vcount = 0;
  endtask

  // Called at posedge+1 while idle; returns at posedge+1 after the accepting edge.
  task automatic send_cmd(input logic [9:0] b, input logic [10:0] l);
    check_eq("cmd_ready_before_cmd", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_base  = b;
    bus.cmd_len   = l;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_and_check(input int b, input int l, input logic rnd);
    logic got_done;
    int   n_last;
    clear_logs();
    rnd_mode = rnd;
    send_cmd(10'(b), 11'(l));
    got_done = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (bus.done) begin
        got_done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    rnd_mode = 1'b0;
    check_eq("done_seen", 32'(got_done), 32'd1);
    @(posedge clk);
    #1;
    check_eq("done_one_cycle", 32'(bus.done), 32'd0);
    check_eq("cmd_ready_after_done", 32'(bus.cmd_ready), 32'd1);
    check_eq("beat_count", beat_data.size(), l);
    check_eq("addr_count", addr_log.size(), l);
    n_last = 0;
    for (int i = 0; i < beat_data.size() && i < l; i++) begin
      if (beat_data[i] !== 8'((b + i) % 1024)) check_eq("beat_data", beat_data[i], (b + i) % 256);
      if (beat_last[i] !== (i == l - 1)) check_eq("beat_last", beat_last[i], (i == l - 1));
      if (beat_last[i]) n_last++;
    end
    for (int i = 0; i < addr_log.size() && i < l; i++)
      if (addr_log[i] != (b + i) % 1024) check_eq("mem_addr_seq", addr_log[i], (b + i) % 1024);
    check_eq("single_last", n_last, 1);
    if (!rnd && beat_cyc.size() == l) check_eq("no_bubbles", beat_cyc[l-1] - beat_cyc[0], l - 1);
  endtask

  initial begin
    logic got;
    for (int i = 0; i < 1024; i++) sram[i] = 8'(i);
    bus.cmd_valid = 1'b0;
    bus.cmd_base  = '0;
    bus.cmd_len   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_eq("rst_mem_ce", 32'(bus.mem_ce), 32'd0);
    check_eq("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_data", 32'(bus.out_data), 32'd0);
    check_eq("rst_out_last", 32'(bus.out_last), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_mem_we", 32'(bus.mem_we), 32'd0);

    // base=0 len=4: cycle-exact latency, throughput and done timing
    clear_logs();
    send_cmd(10'd0, 11'd4);
    check_eq("t1_ce_n1", 32'(bus.mem_ce), 32'd1);
    check_eq("t1_addr_n1", 32'(bus.mem_addr), 32'd0);
    check_eq("t1_cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    check_eq("t1_valid_n2", 32'(bus.out_valid), 32'd0);
    check_eq("t1_addr_n2", 32'(bus.mem_addr), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check_eq("t1_valid", 32'(bus.out_valid), 32'd1);
      check_eq("t1_data", 32'(bus.out_data), 32'(k));
      check_eq("t1_last", 32'(bus.out_last), 32'(k == 3));
    end
    @(posedge clk);
    #1;
    check_eq("t1_done", 32'(bus.done), 32'd1);
    check_eq("t1_valid_after", 32'(bus.out_valid), 32'd0);
    check_eq("t1_cmd_ready_in_done", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    check_eq("t1_done_clear", 32'(bus.done), 32'd0);
    check_eq("t1_cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
    check_eq("t1_addr_hold", 32'(bus.mem_addr), 32'd3);
    check_eq("t1_beats", beat_data.size(), 4);

    // Address wrap
    run_and_check(1022, 4, 1'b0);

    // Random backpressure
    run_and_check(16, 8, 1'b1);

    // Zero-length command
    clear_logs();
    send_cmd(10'd7, 11'd0);
    check_eq("t4_done", 32'(bus.done), 32'd1);
    check_eq("t4_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    check_eq("t4_done_clear", 32'(bus.done), 32'd0);
    check_eq("t4_cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("t4_no_ce", addr_log.size(), 0);
    check_eq("t4_no_valid", vcount, 0);

    // Full sweep followed immediately by a short command
    run_and_check(0, 1024, 1'b0);
    run_and_check(5, 2, 1'b0);

    // Reset in the middle of a command
    clear_logs();
    send_cmd(10'd0, 11'd10);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (beat_data.size() >= 3) begin
        got = 1'b1;
        break;
      end
    end
    check_eq("t6_three_beats", 32'(got), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t6_valid", 32'(bus.out_valid), 32'd0);
    check_eq("t6_ce", 32'(bus.mem_ce), 32'd0);
    check_eq("t6_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_eq("t6_last", 32'(bus.out_last), 32'd0);
    check_eq("t6_addr", 32'(bus.mem_addr), 32'd0);
    rst = 1'b0;
    run_and_check(0, 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
